// File: rtl/unidade_mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   WIDTH       operand and HI/LO width
//   CNT_W       step counter width
//   MD_LATENCY  cycles from accepted start to the done pulse
//   OP_*        operation encodings carried on the op port
//   md_state_t  control FSM states
//   magnitude() two's-complement absolute value (-2^31 maps to 2^31 unsigned)
package unidade_mult_div_pkg;

    localparam int WIDTH      = 32;
    localparam int CNT_W      = $clog2(WIDTH);
    localparam int MD_LATENCY = 33;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } md_state_t;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic             is_signed);
        return (is_signed && x[WIDTH-1]) ? -x : x;
    endfunction

endpackage

// File: rtl/unidade_mult_div.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Runs a 32-step shift-add multiply or restoring divide on operand
// magnitudes, then fixes up signs in one extra cycle and writes HI/LO.
// Ports:
//   clock     rising-edge clock
//   reset     asynchronous, active-high reset
//   start     request pulse, sampled only in IDLE or DONE
//   op        00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   in1       multiplicand / dividend
//   in2       multiplier / divisor
//   busy      high while an operation is in progress (CALC, FIX)
//   done      one-cycle completion pulse
//   div_zero  last completed divide had a zero divisor
//   hi        product[63:32] or remainder
//   lo        product[31:0] or quotient
module unidade_mult_div
    import unidade_mult_div_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t          state;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;    // latched op class
    logic               neg_res;   // negate product / quotient in FIX
    logic               neg_rem;   // remainder takes negative dividend sign
    logic               dz_pend;   // divide-by-zero seen at accept
    logic [WIDTH-1:0]   operand;   // multiplicand (mult) or divisor (div) magnitude
    logic [2*WIDTH-1:0] acc;       // {upper, lower}: {acc_hi, multiplier} or {rem, quot}

    // Decode of the request on the input side
    logic               is_signed_op;
    logic               is_div_op;
    logic [WIDTH-1:0]   in1_mag;
    logic [WIDTH-1:0]   in2_mag;

    // Datapath next values
    logic [WIDTH:0]     mul_sum;   // carry + upper half
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_rem;   // remainder after the left shift, one bit wider
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] step_next;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    always_comb begin
        // NOTE: every signal gets a value before any branch so no latch is inferred.
        is_signed_op = (op == OP_MULT) || (op == OP_DIV);
        is_div_op    = (op == OP_DIVU) || (op == OP_DIV);
        in1_mag      = magnitude(in1, is_signed_op);
        in2_mag      = magnitude(in2, is_signed_op);

        // Shift-add multiply: the 65-bit {carry, acc} shifts right by one,
        // retiring one multiplier bit from the bottom each step.
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};

        // Restoring divide: the shifted remainder can reach 33 bits, but after
        // a conditional subtract it is always below the divisor and fits 32.
        div_rem  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge   = div_rem >= {1'b0, operand};
        div_diff = div_rem[WIDTH-1:0] - operand;
        div_next = div_ge ? {div_diff,           acc[WIDTH-2:0], 1'b1}
                          : {div_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

        step_next = is_div ? div_next : mul_next;

        // Sign fix-up. The divide-by-zero path clears both sign flags, so the
        // raw {in1, all-ones} preloaded into acc passes straight through.
        prod_fixed = neg_res ? -acc : acc;
        fix_hi     = prod_fixed[2*WIDTH-1:WIDTH];
        fix_lo     = prod_fixed[WIDTH-1:0];
        if (is_div) begin
            fix_hi = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            fix_lo = neg_res ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            dz_pend  <= 1'b0;
            operand  <= '0;
            acc      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        is_div   <= is_div_op;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        div_zero <= 1'b0;
                        if (is_div_op && (in2 == '0)) begin
                            acc     <= {in1, {WIDTH{1'b1}}};
                            neg_res <= 1'b0;
                            neg_rem <= 1'b0;
                            dz_pend <= 1'b1;
                            state   <= ST_FIX;
                        end else begin
                            neg_res <= is_signed_op & (in1[WIDTH-1] ^ in2[WIDTH-1]);
                            neg_rem <= is_signed_op & is_div_op & in1[WIDTH-1];
                            dz_pend <= 1'b0;
                            operand <= is_div_op ? in2_mag : in1_mag;
                            acc     <= {{WIDTH{1'b0}}, (is_div_op ? in1_mag : in2_mag)};
                            state   <= ST_CALC;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    acc <= step_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    hi       <= fix_hi;
                    lo       <= fix_lo;
                    div_zero <= dz_pend;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    state    <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
